// File: rtl/g_div_pkg.sv
// Shared types and defaults for the three-axis "g" divider scheduler.
// Optional round-to-nearest build: define ROUND_EN.
package g_div_pkg;
  localparam int unsigned AXIS_X   = 0;
  localparam int unsigned AXIS_Y   = 1;
  localparam int unsigned AXIS_Z   = 2;
  localparam int unsigned NUM_AXES = 3;

  localparam int unsigned DIVISOR_DEFAULT     = 163;
  localparam int unsigned SCALING_DEFAULT     = 64;
  localparam int unsigned DIV_LATENCY_DEFAULT = 20;

  typedef struct packed {
    logic       valid;
    logic [1:0] axis;
    logic       sign;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  // Round-robin successor in X -> Y -> Z -> X order.
  function automatic logic [1:0] axis_next(input logic [1:0] a);
    case (a)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/g_div_scheduler_if.sv
// Handshake bundle between the scheduler (master) and the shared pipelined divider (slave).
interface g_div_scheduler_if;
  logic        div_rfd;
  logic        div_nd;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic [14:0] div_quotient;

  modport master (input div_rfd, input div_quotient,
                  output div_nd, output div_dividend, output div_divisor);
  modport slave  (output div_rfd, output div_quotient,
                  input div_nd, input div_dividend, input div_divisor);
endinterface

// File: rtl/g_div_tag_pipe.sv
// DEPTH-stage tag shift register that travels alongside the divider; RST flushes every stage.
module g_div_tag_pipe
  import g_div_pkg::*;
#(
  parameter int unsigned DEPTH = DIV_LATENCY_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage_r [DEPTH];

  // Shift tags one stage per cycle; flushing drops in-flight results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {TAG_W{1'b0}};
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign tag_out = stage_r[DEPTH-1];
endmodule

// File: rtl/g_div_scheduler.sv
// Shares one pipelined divider between X/Y/Z samples, round-robin, and writes back signed "g" results.
// Optional feature: define ROUND_EN for a round-to-nearest dividend offset of DIVISOR/2.
module g_div_scheduler
  import g_div_pkg::*;
#(
  parameter int unsigned DIVISOR     = DIVISOR_DEFAULT,
  parameter int unsigned SCALING     = SCALING_DEFAULT,
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            din_valid,
  input  logic [9:0]            din_x,
  input  logic [9:0]            din_y,
  input  logic [9:0]            din_z,
  input  logic                  clear_ovr,
  g_div_scheduler_if.master     div_bus,
  output logic [9:0]            acc_x,
  output logic [9:0]            acc_y,
  output logic [9:0]            acc_z,
  output logic [2:0]            acc_valid,
  output logic                  frame_done,
  output logic [2:0]            overrun
);
  localparam logic [15:0] SCALING_W = 16'(SCALING);
`ifdef ROUND_EN
  localparam logic [15:0] ROUND_ADD_W = 16'(DIVISOR / 2);
`else
  localparam logic [15:0] ROUND_ADD_W = 16'd0;
`endif

  logic [2:0]  pend_r, pend_next_s, ovr_evt_s, overrun_r;
  logic [9:0]  pend_data_r [NUM_AXES];
  logic [9:0]  din_s [NUM_AXES];
  logic [9:0]  acc_r [NUM_AXES];
  logic [1:0]  rr_ptr_r, cand1_s, cand2_s, grant_axis_s;
  logic        grant_s, div_nd_r, frame_done_r;
  logic [15:0] div_dividend_r, dividend_s;
  logic [2:0]  acc_valid_r, frame_mask_r, wb_valid_s, frame_all_s;
  tag_t        issue_tag_r, wb_tag_s;
  logic        quot_unused_s;

  // Gather per-axis samples into an indexable array.
  always_comb begin
    din_s[AXIS_X] = din_x;
    din_s[AXIS_Y] = din_y;
    din_s[AXIS_Z] = din_z;
  end

  // Round-robin grant: first pending axis at or after the pointer.
  always_comb begin
    cand1_s = axis_next(rr_ptr_r);
    cand2_s = axis_next(cand1_s);
    grant_s = 1'b0;
    grant_axis_s = rr_ptr_r;
    if (!div_bus.div_rfd) begin
      grant_s = 1'b0;
    end else if (pend_r[rr_ptr_r]) begin
      grant_s = 1'b1;
      grant_axis_s = rr_ptr_r;
    end else if (pend_r[cand1_s]) begin
      grant_s = 1'b1;
      grant_axis_s = cand1_s;
    end else if (pend_r[cand2_s]) begin
      grant_s = 1'b1;
      grant_axis_s = cand2_s;
    end else begin
      grant_s = 1'b0;
    end
    dividend_s = {7'd0, pend_data_r[grant_axis_s][8:0]} * SCALING_W + ROUND_ADD_W;
  end

  // Pending update: an issued axis frees its slot, so a same-cycle sample is not an overrun.
  always_comb begin
    pend_next_s = pend_r;
    ovr_evt_s = 3'b000;
    if (grant_s) begin
      pend_next_s[grant_axis_s] = 1'b0;
    end else begin
      pend_next_s = pend_r;
    end
    for (int i = 0; i < NUM_AXES; i++) begin
      if (din_valid[i]) begin
        ovr_evt_s[i]   = pend_next_s[i];
        pend_next_s[i] = 1'b1;
      end else begin
        ovr_evt_s[i]   = 1'b0;
      end
    end
  end

  // Capture samples, track overrun and register the divider issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_r         <= 3'b000;
      for (int i = 0; i < NUM_AXES; i++) pend_data_r[i] <= 10'd0;
      rr_ptr_r       <= 2'd0;
      overrun_r      <= 3'b000;
      div_nd_r       <= 1'b0;
      div_dividend_r <= 16'd0;
      issue_tag_r    <= {TAG_W{1'b0}};
    end else begin
      pend_r <= pend_next_s;
      for (int i = 0; i < NUM_AXES; i++) begin
        if (din_valid[i]) pend_data_r[i] <= din_s[i];
      end
      overrun_r   <= (clear_ovr ? 3'b000 : overrun_r) | ovr_evt_s;
      div_nd_r    <= grant_s;
      issue_tag_r <= {grant_s, grant_axis_s, pend_data_r[grant_axis_s][9]};
      if (grant_s) begin
        div_dividend_r <= dividend_s;
        rr_ptr_r       <= axis_next(grant_axis_s);
      end
    end
  end

  g_div_tag_pipe #(.DEPTH(DIV_LATENCY)) u_tag_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .tag_in  (issue_tag_r),
    .tag_out (wb_tag_s)
  );

  // Decode the emerging tag into a one-hot update and the frame-complete test.
  always_comb begin
    wb_valid_s = 3'b000;
    if (wb_tag_s.valid) begin
      case (wb_tag_s.axis)
        2'd0:    wb_valid_s = 3'b001;
        2'd1:    wb_valid_s = 3'b010;
        2'd2:    wb_valid_s = 3'b100;
        default: wb_valid_s = 3'b000;
      endcase
    end else begin
      wb_valid_s = 3'b000;
    end
    frame_all_s = frame_mask_r | wb_valid_s;
  end

  // Write quotients back per axis and pulse frame_done when every axis has refreshed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_AXES; i++) acc_r[i] <= 10'd0;
      acc_valid_r  <= 3'b000;
      frame_mask_r <= 3'b000;
      frame_done_r <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_AXES; i++) begin
        if (wb_valid_s[i]) acc_r[i] <= {wb_tag_s.sign, div_bus.div_quotient[8:0]};
      end
      acc_valid_r <= wb_valid_s;
      if (frame_all_s == 3'b111) begin
        frame_done_r <= 1'b1;
        frame_mask_r <= 3'b000;
      end else begin
        frame_done_r <= 1'b0;
        frame_mask_r <= frame_all_s;
      end
    end
  end

  assign quot_unused_s        = ^div_bus.div_quotient[14:9];
  assign div_bus.div_nd       = div_nd_r;
  assign div_bus.div_dividend = div_dividend_r;
  assign div_bus.div_divisor  = 8'(DIVISOR);
  assign acc_x      = acc_r[AXIS_X];
  assign acc_y      = acc_r[AXIS_Y];
  assign acc_z      = acc_r[AXIS_Z];
  assign acc_valid  = acc_valid_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;
endmodule

// File: tb/tb_g_div_scheduler.sv
// Self-checking bench for g_div_scheduler: directed scenarios plus a random run against a queue-based reference.
module tb_g_div_scheduler;
  localparam int L   = 20;
  localparam int DIV = 163;
  localparam int SCL = 64;
`ifdef ROUND_EN
  localparam int RND = 81;
`else
  localparam int RND = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] din_valid;
  logic [9:0] din_x, din_y, din_z;
  logic       clear_ovr;
  logic       rfd;
  logic [9:0] acc_x, acc_y, acc_z;
  logic [2:0] acc_valid, overrun;
  logic       frame_done;

  g_div_scheduler_if bus ();

  g_div_scheduler dut (
    .CLK(CLK), .RST(RST), .din_valid(din_valid), .din_x(din_x), .din_y(din_y), .din_z(din_z),
    .clear_ovr(clear_ovr), .div_bus(bus), .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
    .acc_valid(acc_valid), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // Pipelined divider: quotient of a div_nd issue is on div_quotient L cycles later; junk otherwise.
  int unsigned dq [L];
  always @(posedge CLK) begin
    for (int k = L - 1; k > 0; k--) dq[k] <= dq[k-1];
    if (bus.div_nd === 1'b1 && bus.div_divisor != 8'd0) dq[0] <= bus.div_dividend / bus.div_divisor;
    else dq[0] <= $urandom_range(0, 32767);
  end
  assign bus.div_quotient = 15'(dq[L-1]);
  assign bus.div_rfd = rfd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  typedef struct { int due; int axis; bit sgn; int q; } wb_t;
  wb_t      wbq [$];
  bit [2:0] m_pend, m_ovr, m_av, m_mask;
  int       m_mag [3];
  bit       m_sgn [3];
  int       m_rr, m_div;
  bit       m_nd, m_fd;
  bit [9:0] m_acc [3];

  function automatic int exp_q(int mag);
    return (mag * SCL + RND) / DIV;
  endfunction

  function automatic logic [9:0] get_din(int i);
    case (i)
      0: return din_x;
      1: return din_y;
      default: return din_z;
    endcase
  endfunction

  // Advance the reference by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int g, n;
    bit [2:0] ev, av;
    logic [9:0] d;
    wb_t w;
    n = cyc + 1;
    if (RST) begin
      wbq.delete();
      m_pend = 0; m_ovr = 0; m_av = 0; m_mask = 0; m_rr = 0; m_div = 0; m_nd = 0; m_fd = 0;
      for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_mag[i] = 0; m_sgn[i] = 0; end
    end else begin
      av = 0;
      while (wbq.size() > 0 && wbq[0].due <= n) begin
        w = wbq.pop_front();
        if (w.due == n) begin m_acc[w.axis] = {w.sgn, 9'(w.q)}; av[w.axis] = 1'b1; end
      end
      m_av = av;
      if ((m_mask | av) == 3'b111) begin m_fd = 1; m_mask = 0; end
      else begin m_fd = 0; m_mask = m_mask | av; end
      g = -1;
      if (rfd) for (int k = 0; k < 3; k++) if (g < 0 && m_pend[(m_rr + k) % 3]) g = (m_rr + k) % 3;
      if (g >= 0) begin
        m_nd = 1;
        m_div = m_mag[g] * SCL + RND;
        wbq.push_back('{n + L + 1, g, m_sgn[g], m_div / DIV});
        m_pend[g] = 0;
        m_rr = (g + 1) % 3;
      end else m_nd = 0;
      ev = 0;
      for (int i = 0; i < 3; i++) begin
        d = get_din(i);
        if (din_valid[i]) begin
          ev[i] = m_pend[i]; m_pend[i] = 1; m_mag[i] = int'(d[8:0]); m_sgn[i] = d[9];
        end
      end
      m_ovr = (clear_ovr ? 3'b000 : m_ovr) | ev;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; din_valid = 3'b000; clear_ovr = 1'b0; rfd = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({acc_x, acc_y, acc_z} !== 30'd0) begin failures++; $display("FAIL reset_acc got=%0h exp=0", {acc_x, acc_y, acc_z}); end
    checks++; if ({acc_valid, frame_done, overrun} !== 7'd0) begin failures++; $display("FAIL reset_flags got=%0h exp=0", {acc_valid, frame_done, overrun}); end
    checks++; if (bus.div_nd !== 1'b0 || bus.div_dividend !== 16'd0) begin failures++; $display("FAIL reset_issue got=%0h/%0h exp=0/0", bus.div_nd, bus.div_dividend); end
    checks++; if (bus.div_divisor !== 8'd163) begin failures++; $display("FAIL divisor got=%0d exp=163", bus.div_divisor); end
  endtask

  task automatic test_single_x();
    bit early;
    logic [15:0] exp_d;
    logic [9:0] exp_x;
    do_reset();
    rfd = 1'b1; din_x = 10'h1FF; din_valid = 3'b001;
    tick();
    din_valid = 3'b000;
    tick();
    exp_d = 16'(511 * SCL + RND);
    checks++; if (bus.div_nd !== 1'b1 || bus.div_dividend !== exp_d) begin failures++; $display("FAIL x_issue got=%0h/%0d exp=1/%0d", bus.div_nd, bus.div_dividend, exp_d); end
    early = 0;
    for (int k = 1; k <= L; k++) begin tick(); if (acc_valid !== 3'b000) early = 1; end
    checks++; if (early) begin failures++; $display("FAIL x_early_valid got=1 exp=0"); end
    tick();
    exp_x = (RND != 0) ? 10'h0C9 : 10'h0C8;
    checks++; if (acc_valid !== 3'b001 || acc_x !== exp_x) begin failures++; $display("FAIL x_result got=%0h/%0h exp=1/%0h", acc_valid, acc_x, exp_x); end
  endtask

  task automatic test_y_sign();
    int lat;
    logic [15:0] exp_d;
    logic [9:0] exp_y;
    do_reset();
    rfd = 1'b1; din_y = 10'h3A3; din_valid = 3'b010;
    tick();
    din_valid = 3'b000;
    tick();
    exp_d = (RND != 0) ? 16'd26897 : 16'd26816;
    exp_y = (RND != 0) ? 10'h2A5 : 10'h2A4;
    checks++; if (bus.div_nd !== 1'b1 || bus.div_dividend !== exp_d) begin failures++; $display("FAIL y_issue got=%0h/%0d exp=1/%0d", bus.div_nd, bus.div_dividend, exp_d); end
    lat = 0;
    for (int k = 1; k <= L + 4 && lat == 0; k++) begin tick(); if (acc_valid !== 3'b000) lat = k; end
    checks++; if (lat != L + 1) begin failures++; $display("FAIL y_latency got=%0d exp=%0d", lat, L + 1); end
    checks++; if (acc_valid !== 3'b010 || acc_y !== exp_y) begin failures++; $display("FAIL y_result got=%0h/%0h exp=2/%0h", acc_valid, acc_y, exp_y); end
  endtask

  task automatic test_all_axes();
    int xm, ym, fd_cnt, fd_ok;
    logic [15:0] exp_d [3];
    do_reset();
    xm = $urandom_range(1, 511); ym = $urandom_range(1, 511);
    rfd = 1'b1; din_x = {1'b1, 9'(xm)}; din_y = {1'b0, 9'(ym)}; din_z = 10'h000; din_valid = 3'b111;
    exp_d[0] = 16'(xm * SCL + RND); exp_d[1] = 16'(ym * SCL + RND); exp_d[2] = 16'(RND);
    tick();
    din_valid = 3'b000;
    for (int a = 0; a < 3; a++) begin
      tick();
      checks++; if (bus.div_nd !== 1'b1 || bus.div_dividend !== exp_d[a]) begin failures++; $display("FAIL order_axis%0d got=%0h/%0d exp=1/%0d", a, bus.div_nd, bus.div_dividend, exp_d[a]); end
    end
    fd_cnt = 0; fd_ok = 0;
    for (int k = 0; k < L + 6; k++) begin
      tick();
      if (frame_done === 1'b1) begin fd_cnt++; if (acc_valid === 3'b100) fd_ok = 1; end
    end
    checks++; if (fd_cnt != 1 || fd_ok != 1) begin failures++; $display("FAIL frame_done got=%0d/%0d exp=1/1", fd_cnt, fd_ok); end
    checks++; if (acc_z !== 10'h000) begin failures++; $display("FAIL z_zero got=%0h exp=0", acc_z); end
    checks++; if (acc_x !== {1'b1, 9'(exp_q(xm))} || acc_y !== {1'b0, 9'(exp_q(ym))}) begin failures++; $display("FAIL xy_result got=%0h/%0h exp=%0h/%0h", acc_x, acc_y, {1'b1, 9'(exp_q(xm))}, {1'b0, 9'(exp_q(ym))}); end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_d;
    do_reset();
    rfd = 1'b0;
    din_x = 10'h055; din_valid = 3'b001; tick();
    din_x = 10'h1A0; tick();
    din_valid = 3'b000; tick();
    checks++; if (overrun !== 3'b001 || bus.div_nd !== 1'b0) begin failures++; $display("FAIL ovr_set got=%0h/%0h exp=1/0", overrun, bus.div_nd); end
    rfd = 1'b1; tick();
    exp_d = 16'(32'h1A0 * SCL + RND);
    checks++; if (bus.div_nd !== 1'b1 || bus.div_dividend !== exp_d) begin failures++; $display("FAIL ovr_latest got=%0h/%0d exp=1/%0d", bus.div_nd, bus.div_dividend, exp_d); end
    clear_ovr = 1'b1; tick(); clear_ovr = 1'b0;
    checks++; if (overrun !== 3'b000) begin failures++; $display("FAIL ovr_clear got=%0h exp=0", overrun); end
    rfd = 1'b0;
    din_valid = 3'b100; din_z = 10'h011; tick();
    clear_ovr = 1'b1; tick();
    clear_ovr = 1'b0; din_valid = 3'b000; tick();
    checks++; if (overrun !== 3'b100) begin failures++; $display("FAIL ovr_clear_race got=%0h exp=4", overrun); end
  endtask

  task automatic test_rst_inflight();
    bit seen;
    int lat;
    do_reset();
    rfd = 1'b1; din_x = 10'h123; din_y = 10'h0F0; din_valid = 3'b011;
    tick();
    din_valid = 3'b000;
    tick(); tick();
    RST = 1'b1; tick(); RST = 1'b0;
    checks++; if ({acc_x, acc_y, acc_z, acc_valid, frame_done, overrun, bus.div_nd} !== 38'd0 || bus.div_dividend !== 16'd0) begin failures++; $display("FAIL rst_outputs got=nonzero exp=0"); end
    seen = 0;
    for (int k = 0; k < L + 2; k++) begin tick(); if (acc_valid !== 3'b000 || frame_done !== 1'b0) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL rst_discard got=1 exp=0"); end
    din_z = 10'h2FF; din_valid = 3'b100; tick(); din_valid = 3'b000;
    lat = 0;
    for (int k = 1; k <= L + 4 && lat == 0; k++) begin tick(); if (acc_valid !== 3'b000) lat = k; end
    checks++; if (acc_valid !== 3'b100 || acc_z !== {1'b1, 9'(exp_q(255))}) begin failures++; $display("FAIL rst_recover got=%0h/%0h exp=4/%0h", acc_valid, acc_z, {1'b1, 9'(exp_q(255))}); end
  endtask

  task automatic test_back_to_back();
    int prev, xm;
    bit found, bad_issue, bad_ovr;
    do_reset();
    rfd = 1'b1; prev = 0; bad_issue = 0; bad_ovr = 0;
    for (int c = 0; c < 12; c++) begin
      xm = $urandom_range(0, 255);
      din_x = {1'b0, 9'(xm)}; din_valid = 3'b001;
      tick();
      if (c > 0) begin
        if (bus.div_nd !== 1'b1 || bus.div_dividend !== 16'(prev * SCL + RND)) bad_issue = 1;
        if (overrun !== 3'b000) bad_ovr = 1;
      end
      prev = xm;
    end
    checks++; if (bad_issue) begin failures++; $display("FAIL b2b_issue got=gap exp=every_cycle"); end
    checks++; if (bad_ovr) begin failures++; $display("FAIL b2b_overrun got=set exp=0"); end
    din_y = {1'b0, 9'd300}; din_valid = 3'b011;
    tick();
    din_valid = 3'b001;
    found = 0;
    for (int k = 0; k < 4 && !found; k++) begin
      tick();
      if (bus.div_nd === 1'b1 && bus.div_dividend === 16'(300 * SCL + RND)) found = 1;
    end
    din_valid = 3'b000;
    checks++; if (!found) begin failures++; $display("FAIL y_starved got=0 exp=1"); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      din_valid = {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)};
      din_x = 10'($urandom); din_y = 10'($urandom); din_z = 10'($urandom);
      rfd = ($urandom_range(0, 3) != 0);
      clear_ovr = ($urandom_range(0, 19) == 0);
      RST = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (bus.div_nd !== m_nd || (m_nd && bus.div_dividend !== 16'(m_div))) begin failures++; $display("FAIL rnd_issue c=%0d got=%0h/%0d exp=%0h/%0d", c, bus.div_nd, bus.div_dividend, m_nd, m_div); end
      checks++; if (acc_valid !== m_av || frame_done !== m_fd) begin failures++; $display("FAIL rnd_valid c=%0d got=%0h/%0h exp=%0h/%0h", c, acc_valid, frame_done, m_av, m_fd); end
      checks++; if (acc_x !== m_acc[0] || acc_y !== m_acc[1] || acc_z !== m_acc[2]) begin failures++; $display("FAIL rnd_acc c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, acc_x, acc_y, acc_z, m_acc[0], m_acc[1], m_acc[2]); end
      checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rnd_overrun c=%0d got=%0h exp=%0h", c, overrun, m_ovr); end
    end
    RST = 1'b0; din_valid = 3'b000; clear_ovr = 1'b0;
  endtask

  initial begin
    RST = 1'b1; din_valid = 3'b000; din_x = 10'd0; din_y = 10'd0; din_z = 10'd0; clear_ovr = 1'b0; rfd = 1'b0;
    test_reset();
    test_single_x();
    test_y_sign();
    test_all_axes();
    test_overrun();
    test_rst_inflight();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
